// File: rtl/circuito_exp5_pkg.sv
// Shared definitions for circuito_exp5: state codes, sequence ROM and timing defaults.
package circuito_exp5_pkg;

  typedef logic [3:0] nibble_t;

  // Default move timeout: 5 s at a 1 kHz clock.
  localparam int unsigned TIMEOUT_CYCLES_DEF = 5000;
  localparam int unsigned STATE_W            = 4;

  // State codes double as the value shown on db_estado.
  localparam logic [STATE_W-1:0] ST_INICIAL     = 4'h0;
  localparam logic [STATE_W-1:0] ST_PREPARA     = 4'h1;
  localparam logic [STATE_W-1:0] ST_ESPERA      = 4'h2;
  localparam logic [STATE_W-1:0] ST_REGISTRA    = 4'h3;
  localparam logic [STATE_W-1:0] ST_COMPARA     = 4'h4;
  localparam logic [STATE_W-1:0] ST_PROX_JOGADA = 4'h5;
  localparam logic [STATE_W-1:0] ST_PROX_RODADA = 4'h7;
  localparam logic [STATE_W-1:0] ST_GANHOU      = 4'hC;
  localparam logic [STATE_W-1:0] ST_PERDEU      = 4'hE;

  // Sequence the player must reproduce, one one-hot button word per move index.
  function automatic nibble_t rom_word(input nibble_t addr);
    case (addr)
      4'd0:  rom_word = 4'h1;
      4'd1:  rom_word = 4'h2;
      4'd2:  rom_word = 4'h4;
      4'd3:  rom_word = 4'h8;
      4'd4:  rom_word = 4'h4;
      4'd5:  rom_word = 4'h2;
      4'd6:  rom_word = 4'h1;
      4'd7:  rom_word = 4'h1;
      4'd8:  rom_word = 4'h2;
      4'd9:  rom_word = 4'h2;
      4'd10: rom_word = 4'h4;
      4'd11: rom_word = 4'h4;
      4'd12: rom_word = 4'h8;
      4'd13: rom_word = 4'h8;
      4'd14: rom_word = 4'h1;
      default: rom_word = 4'h4;
    endcase
  endfunction

endpackage

// File: rtl/circuito_exp5_hexa7seg.sv
// 4-bit value to 7-segment pattern, gfedcba order, segments active-low.
// Ports: hex_i - value to display; seg_o - segment drive.
module hexa7seg
  import circuito_exp5_pkg::*;
(
  input  nibble_t    hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/circuito_exp5.sv
// Sequence memory game: the player repeats a growing prefix of a ROM sequence
// on four buttons, one round longer each time, with a per-move timeout.
// Ports: clock/reset (async, active-high); jogar starts a game; botoes are the
// one-hot buttons; ganhou/perdeu/pronto report the result; leds show the last
// registered move; db_* expose internal flags and 7-segment debug displays.
module circuito_exp5
  import circuito_exp5_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_sequencia,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_fimseq,
  output logic       db_igualseq,
  output logic       db_igualjogada,
  output logic       db_tem_jogada,
  output logic       db_timeout
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  nibble_t            idx_q, idx_d;
  nibble_t            lim_q, lim_d;
  nibble_t            jog_q, jog_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               btn_prev_q;

  nibble_t rom_q_word;
  logic    tem_jogada, igualjogada, igualseq, fimseq, timeout;

  // Datapath flags
  assign rom_q_word  = rom_word(idx_q);
  assign tem_jogada  = (|botoes) & ~btn_prev_q;
  assign igualjogada = (jog_q == rom_q_word);
  assign igualseq    = (idx_q == lim_q);
  assign fimseq      = (lim_q == 4'hF);
  assign timeout     = (tmr_q == TMR_LAST);

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INICIAL;
      idx_q      <= '0;
      lim_q      <= '0;
      jog_q      <= '0;
      tmr_q      <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lim_q      <= lim_d;
      jog_q      <= jog_d;
      tmr_q      <= tmr_d;
      btn_prev_q <= |botoes;
    end
  end

  // Next-state and datapath control; the timer only survives while in ESPERA
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lim_d   = lim_q;
    jog_d   = jog_q;
    tmr_d   = '0;
    case (state_q)
      ST_INICIAL: begin
        if (jogar) state_d = ST_PREPARA;
      end
      ST_PREPARA: begin
        idx_d   = '0;
        lim_d   = '0;
        jog_d   = '0;
        state_d = ST_ESPERA;
      end
      ST_ESPERA: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tem_jogada)   state_d = ST_REGISTRA;
        else if (timeout) state_d = ST_PERDEU;
      end
      ST_REGISTRA: begin
        jog_d   = botoes;
        state_d = ST_COMPARA;
      end
      ST_COMPARA: begin
        if (!igualjogada)  state_d = ST_PERDEU;
        else if (!igualseq) state_d = ST_PROX_JOGADA;
        else if (fimseq)   state_d = ST_GANHOU;
        else               state_d = ST_PROX_RODADA;
      end
      ST_PROX_JOGADA: begin
        idx_d   = idx_q + 4'd1;
        state_d = ST_ESPERA;
      end
      ST_PROX_RODADA: begin
        lim_d   = lim_q + 4'd1;
        idx_d   = '0;
        state_d = ST_ESPERA;
      end
      ST_GANHOU, ST_PERDEU: begin
        if (jogar) state_d = ST_PREPARA;
      end
      default: state_d = ST_INICIAL;
    endcase
  end

  // Result flags decode straight from the state register
  assign ganhou = (state_q == ST_GANHOU);
  assign perdeu = (state_q == ST_PERDEU);
  assign pronto = ganhou | perdeu;
  assign leds   = jog_q;

  assign db_igual       = (botoes == rom_q_word);
  assign db_clock       = clock;
  assign db_iniciar     = jogar;
  assign db_fimseq      = fimseq;
  assign db_igualseq    = igualseq;
  assign db_igualjogada = igualjogada;
  assign db_tem_jogada  = tem_jogada;
  assign db_timeout     = timeout;

  hexa7seg u_seg_contagem  (.hex_i(idx_q),      .seg_o(db_contagem));
  hexa7seg u_seg_memoria   (.hex_i(rom_q_word), .seg_o(db_memoria));
  hexa7seg u_seg_estado    (.hex_i(state_q),    .seg_o(db_estado));
  hexa7seg u_seg_jogada    (.hex_i(jog_q),      .seg_o(db_jogadafeita));
  hexa7seg u_seg_sequencia (.hex_i(lim_q),      .seg_o(db_sequencia));

endmodule

// File: tb/tb_circuito_exp5.sv
// Scoreboard bench for circuito_exp5: stimulus pushes expected moves/results,
// a monitor pops and compares them when the DUT reaches COMPARA or a final state.
module tb_circuito_exp5;

  localparam int unsigned T = 300;
  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG4 = 7'b0011001;
  localparam logic [6:0] SEGF = 7'b0001110;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic [3:0] botoes;
  logic       ganhou, perdeu, pronto, db_igual;
  logic [3:0] leds;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_sequencia;
  logic       db_clock, db_iniciar, db_fimseq, db_igualseq, db_igualjogada;
  logic       db_tem_jogada, db_timeout;

  always #5 clock = ~clock;

  circuito_exp5 #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
    .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
    .db_sequencia(db_sequencia), .db_clock(db_clock), .db_iniciar(db_iniciar),
    .db_fimseq(db_fimseq), .db_igualseq(db_igualseq),
    .db_igualjogada(db_igualjogada), .db_tem_jogada(db_tem_jogada),
    .db_timeout(db_timeout)
  );

  logic [3:0] rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_moves [$];
  bit         exp_end   [$];   // 1 = won, 0 = lost
  int tem_pulses = 0;
  int to_pulses  = 0;
  int moves_sent = 0;

  // Reference model: round length (moves in current round) and position within it
  int rnd = 1;
  int pos = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares registered move at COMPARA and the result when pronto rises
  initial begin : monitor
    logic pr_prev;
    bit   e;
    pr_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (db_tem_jogada) tem_pulses++;
      if (db_timeout) to_pulses++;
      if (!reset && db_estado == SEG4) begin
        if (exp_moves.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_move: leds=%0h with no move pending", leds);
        end else begin
          check("leds_at_compare", 32'(leds), 32'(exp_moves.pop_front()));
        end
      end
      if (pronto && !pr_prev) begin
        if (exp_end.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_end: ganhou=%0b perdeu=%0b with no result pending", ganhou, perdeu);
        end else begin
          e = exp_end.pop_front();
          check("result_ganhou", 32'(ganhou), 32'(e));
          check("result_perdeu", 32'(perdeu), 32'(!e));
        end
      end
      pr_prev = pronto;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    jogar  = 1'b0;
    botoes = 4'h0;
    tick(2);
    reset = 1'b0;
    tick(1);
    rnd  = 1;
    pos  = 0;
    done = 1'b0;
  endtask

  task automatic start_game();
    jogar = 1'b1;
    tick(5);
    jogar = 1'b0;
    rnd  = 1;
    pos  = 0;
    done = 1'b0;
  endtask

  // Issue one press; the model decides what the DUT must do with it
  task automatic play_move(input logic [3:0] v, input int hold, input int gap, input bit chk_lat);
    exp_moves.push_back(v);
    moves_sent++;
    if (v != rom[pos]) begin
      exp_end.push_back(1'b0);
      done = 1'b1;
    end else begin
      pos++;
      if (pos == rnd) begin
        if (rnd == 16) begin
          exp_end.push_back(1'b1);
          done = 1'b1;
        end else begin
          rnd++;
          pos = 0;
        end
      end
    end
    botoes = v;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      if (chk_lat && i == 2) begin
        check("perdeu_within_3", 32'(perdeu), 32'd1);
        check("ganhou_on_loss", 32'(ganhou), 32'd0);
      end
    end
    botoes = 4'h0;
    tick(gap);
  endtask

  task automatic wait_end(input int budget);
    int k;
    k = 0;
    while (!pronto && k < budget) begin
      tick(1);
      k++;
    end
    check("end_reached", 32'(pronto), 32'd1);
  endtask

  // mode 0: win; mode 1: wrong press at move stop_at; mode 2: stall after stop_at moves
  task automatic play_game(input int mode, input int stop_at);
    int n;
    int p0;
    logic [3:0] v;
    n = 0;
    start_game();
    while (!done) begin
      if (mode == 2 && n == stop_at) begin
        p0 = to_pulses;
        exp_end.push_back(1'b0);
        done = 1'b1;
        wait_end(T + 40);
        check("timeout_pulse_rand", 32'(to_pulses - p0), 32'd1);
      end else begin
        v = rom[pos];
        if (mode == 1 && n == stop_at) v = {v[2:0], v[3]};
        play_move(v, $urandom_range(2, 10), $urandom_range(3, 10), 1'b0);
        n++;
      end
    end
    if (mode != 2) wait_end(20);
  endtask

  initial begin : stimulus
    int p0;
    do_reset();

    // Idle after reset
    tick(25);
    check("rst_estado", 32'(db_estado), 32'(SEG0));
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_ganhou", 32'(ganhou), 32'd0);
    check("rst_perdeu", 32'(perdeu), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_contagem", 32'(db_contagem), 32'(SEG0));

    // Buttons in INICIAL are ignored
    botoes = 4'h2;
    tick(4);
    botoes = 4'h0;
    tick(2);
    check("inicial_press_estado", 32'(db_estado), 32'(SEG0));
    check("inicial_press_leds", 32'(leds), 32'd0);

    // One held press gives one pulse; then a wrong move in round 2
    start_game();
    p0 = tem_pulses;
    play_move(4'h1, 10, 10, 1'b0);
    check("single_pulse", 32'(tem_pulses - p0), 32'd1);
    check("single_leds", 32'(leds), 32'h1);
    play_move(4'h1, 10, 10, 1'b0);
    play_move(4'h4, 10, 10, 1'b1);
    wait_end(10);

    // Buttons in a final state are ignored
    botoes = 4'h2;
    tick(5);
    botoes = 4'h0;
    tick(2);
    check("final_press_perdeu", 32'(perdeu), 32'd1);
    check("final_press_leds", 32'(leds), 32'h4);

    // Full correct game
    start_game();
    moves_sent = 0;
    while (!done) play_move(rom[pos], 10, 10, 1'b0);
    wait_end(10);
    check("full_moves", 32'(moves_sent), 32'd136);
    check("full_ganhou", 32'(ganhou), 32'd1);
    check("full_pronto", 32'(pronto), 32'd1);
    check("full_perdeu", 32'(perdeu), 32'd0);
    check("full_fimseq", 32'(db_fimseq), 32'd1);
    check("full_sequencia", 32'(db_sequencia), 32'(SEGF));

    // Timeout in ESPERA with no press
    start_game();
    p0 = to_pulses;
    exp_end.push_back(1'b0);
    done = 1'b1;
    wait_end(T + 20);
    check("timeout_pulse", 32'(to_pulses - p0), 32'd1);
    check("timeout_perdeu", 32'(perdeu), 32'd1);
    check("timeout_pronto", 32'(pronto), 32'd1);

    // Reset mid-game, then a complete replay
    start_game();
    for (int i = 0; i < 10; i++) play_move(rom[pos], 10, 10, 1'b0);
    do_reset();
    check("midrst_estado", 32'(db_estado), 32'(SEG0));
    check("midrst_leds", 32'(leds), 32'd0);
    check("midrst_sequencia", 32'(db_sequencia), 32'(SEG0));
    start_game();
    while (!done) play_move(rom[pos], 10, 10, 1'b0);
    wait_end(10);
    check("replay_ganhou", 32'(ganhou), 32'd1);

    // Randomized games
    for (int g = 0; g < 6; g++) begin
      play_game(int'($urandom_range(0, 2)), int'($urandom_range(0, 135)));
    end

    tick(5);
    check("moves_drained", 32'(exp_moves.size()), 32'd0);
    check("results_drained", 32'(exp_end.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
